// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: the hex font table and the lookup helper.
// Segment vectors are {a,b,c,d,e,f,g}, active-high, with a as the MSB.
package seg7_pkg;

    localparam logic [6:0] FONT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex-nibble to seven-segment decoder, active-high.
// It is a thin wrapper around the package font so that other blocks can reuse the decoder.
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment driver with blanking, leading-zero suppression and PWM dimming.
// New content is double-buffered and is swapped in only when the scan wraps to digit 0.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_LOG2    = 18,
    parameter int BRIGHT_W    = 3,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW ? '1 : '0;
    localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic DP_OFF = SEG_ACT_LOW;

    logic [DIV_LOG2-1:0]     cnt_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pendData_q, dispData_q;
    logic [NUM_DIGITS-1:0]   pendDp_q, dispDp_q;
    logic [NUM_DIGITS-1:0]   pendBlank_q, dispBlank_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frameStart_q;

    logic                    terminal;
    logic                    wrap;
    logic [BRIGHT_W-1:0]     phase;
    logic                    pwmOn;
    logic [NUM_DIGITS-1:0]   suppress;
    logic                    zeroAbove;
    logic [3:0]              curNibble;
    logic [6:0]              fontSeg;
    logic                    lit;

    assign terminal = &cnt_q;
    assign wrap     = terminal && (idx_q == LAST_IDX);
    assign phase    = cnt_q[DIV_LOG2-1 -: BRIGHT_W];
    assign pwmOn    = (phase <= brightness);

    // Walk down from the leftmost digit; a digit is suppressed while everything from it upwards is zero.
    always_comb begin
        suppress  = '0;
        zeroAbove = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zeroAbove   = zeroAbove && (dispData_q[4*i +: 4] == 4'h0);
            suppress[i] = lz_suppress && zeroAbove;
        end
    end

    assign curNibble = dispData_q[{idx_q, 2'b00} +: 4];

    seg7_hex_font uFont (
        .nibble_i (curNibble),
        .seg_o    (fontSeg)
    );

    assign lit = pwmOn && !dispBlank_q[idx_q] && !suppress[idx_q];

    always_comb begin
        idx_d = idx_q;
        if (terminal) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        if (lit) begin
            an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
            seg_d = fontSeg ^ SEG_OFF;
            dp_d  = dispDp_q[idx_q] ^ DP_OFF;
        end
    end

    // The display buffer takes the pending value held before the wrap edge, so a load on that edge lands one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pendData_q   <= '0;
            pendDp_q     <= '0;
            pendBlank_q  <= '0;
            dispData_q   <= '0;
            dispDp_q     <= '0;
            dispBlank_q  <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frameStart_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_q + DIV_LOG2'(1);
            idx_q        <= idx_d;
            frameStart_q <= wrap;
            if (load) begin
                pendData_q  <= data;
                pendDp_q    <= dp_in;
                pendBlank_q <= blank;
            end
            if (wrap) begin
                dispData_q  <= pendData_q;
                dispDp_q    <= pendDp_q;
                dispBlank_q <= pendBlank_q;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an          = an_q;
    assign a_to_g      = seg_q;
    assign dp          = dp_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised bench for seg7_scan, checked every cycle against a time-based reference model.
// The model derives slot, digit and PWM phase from the number of cycles since reset.
module tb_seg7_scan;

    localparam int ND    = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dpIn;
    logic [3:0]  blank;
    logic        load;
    logic        lzSuppress;
    logic [1:0]  brightness;
    logic [6:0]  aToG;
    logic        dp;
    logic [3:0]  an;
    logic        frameStart;

    seg7_scan #(
        .NUM_DIGITS  (4),
        .DIV_LOG2    (4),
        .BRIGHT_W    (2),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .dp_in       (dpIn),
        .blank       (blank),
        .load        (load),
        .lz_suppress (lzSuppress),
        .brightness  (brightness),
        .a_to_g      (aToG),
        .dp          (dp),
        .an          (an),
        .frame_start (frameStart)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] fontTable [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: cycles since reset plus the user-visible pending/display contents.
    int unsigned tCyc = 0;
    logic [15:0] mPendData = '0, mDispData = '0;
    logic [3:0]  mPendDp = '0, mDispDp = '0, mPendBlank = '0, mDispBlank = '0;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp, expFs;
    bit          modelValid = 0;
    int          mDigit, mPhase;
    logic [3:0]  mNib;
    bit          mSupp, mLit;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            tCyc = 0;
            mPendData = '0; mDispData = '0;
            mPendDp = '0; mDispDp = '0; mPendBlank = '0; mDispBlank = '0;
            expAn = 4'hF; expSeg = 7'h7F; expDp = 1'b1; expFs = 1'b0;
        end else begin
            mDigit = (tCyc / SLOT) % ND;
            mPhase = (tCyc % SLOT) / 4;
            mNib   = 4'((mDispData >> (4 * mDigit)) & 16'hF);
            mSupp  = lzSuppress && (mDigit > 0) && ((mDispData >> (4 * mDigit)) == 16'h0);
            mLit   = (mPhase <= int'(brightness)) && !mDispBlank[mDigit] && !mSupp;
            expAn  = mLit ? ~(4'b0001 << mDigit) : 4'hF;
            expSeg = mLit ? ~fontTable[mNib] : 7'h7F;
            expDp  = mLit ? ~mDispDp[mDigit] : 1'b1;
            expFs  = ((tCyc % FRAME) == FRAME - 1);
            if (expFs) begin
                mDispData = mPendData; mDispDp = mPendDp; mDispBlank = mPendBlank;
            end
            if (load) begin
                mPendData = data; mPendDp = dpIn; mPendBlank = blank;
            end
            tCyc++;
        end
        modelValid = 1;
    end

    initial forever begin
        @(negedge clk);
        if (modelValid) begin
            checkOutput("an", an, expAn);
            checkOutput("a_to_g", aToG, expSeg);
            checkOutput("dp", dp, expDp);
            checkOutput("frame_start", frameStart, expFs);
            checkOutput("an_onehot", ($countones(~an) <= 1), 1);
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpV, input logic [3:0] blankV);
        @(negedge clk);
        data = d; dpIn = dpV; blank = blankV; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitFrameCycle(input int target);
        int guard = 0;
        while (((tCyc % FRAME) != target) && (guard < 4 * FRAME)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * FRAME) checkOutput("wait_timeout", guard, 0);
    endtask

    int         litCnt [4];
    int         dpCnt  [4];
    logic [6:0] litSeg [4];

    // Observe one full frame of pins and tally which digits were lit, for how long, and with what pattern.
    task automatic measureFrame();
        for (int d = 0; d < 4; d++) begin
            litCnt[d] = 0; dpCnt[d] = 0; litSeg[d] = 7'h7F;
        end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (an == ~(4'b0001 << d)) begin
                    litCnt[d]++;
                    litSeg[d] = aToG;
                    if (dp == 1'b0) dpCnt[d]++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; data = '0; dpIn = '0; blank = '0; load = 1'b0;
        lzSuppress = 1'b0; brightness = 2'd3;
        repeat (3) @(negedge clk);
        checkOutput("rst_an", an, 4'hF);
        checkOutput("rst_seg", aToG, 7'h7F);
        checkOutput("rst_dp", dp, 1'b1);
        checkOutput("rst_fs", frameStart, 1'b0);
        rst = 1'b0;

        applyStimulus(16'h12AF, 4'h0, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        measureFrame();
        checkOutput("full_cnt0", litCnt[0], 16);
        checkOutput("full_cnt3", litCnt[3], 16);
        checkOutput("seg_F", litSeg[0], 7'b0111000);
        checkOutput("seg_A", litSeg[1], 7'b0001000);
        checkOutput("seg_2", litSeg[2], 7'b0010010);
        checkOutput("seg_1", litSeg[3], 7'b1001111);

        brightness = 2'd0;
        repeat (2) @(negedge clk);
        measureFrame();
        checkOutput("bright0_cnt1", litCnt[1], 4);
        brightness = 2'd2;
        repeat (2) @(negedge clk);
        measureFrame();
        checkOutput("bright2_cnt2", litCnt[2], 12);

        brightness = 2'd3; lzSuppress = 1'b1;
        applyStimulus(16'h0005, 4'h0, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        measureFrame();
        checkOutput("lz5_mask", {litCnt[3] > 0, litCnt[2] > 0, litCnt[1] > 0, litCnt[0] > 0}, 4'b0001);
        checkOutput("lz5_seg", litSeg[0], 7'b0100100);
        applyStimulus(16'h0000, 4'h0, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        measureFrame();
        checkOutput("lz0_cnt0", litCnt[0], 16);
        checkOutput("lz0_seg", litSeg[0], 7'b0000001);
        applyStimulus(16'h0105, 4'h0, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        measureFrame();
        checkOutput("lz105_mask", {litCnt[3] > 0, litCnt[2] > 0, litCnt[1] > 0, litCnt[0] > 0}, 4'b0111);

        lzSuppress = 1'b0;
        waitFrameCycle(SLOT + 3);
        applyStimulus(16'h9999, 4'h0, 4'h0);
        waitFrameCycle(FRAME - 1);
        data = 16'h4567; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        waitFrameCycle(2 * SLOT + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_an", an, 4'hF);
        checkOutput("midrst_seg", aToG, 7'h7F);
        checkOutput("midrst_dp", dp, 1'b1);
        applyStimulus(16'h4321, 4'b0100, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        measureFrame();
        checkOutput("dp_digit2", dpCnt[2], 16);
        checkOutput("dp_digit0", dpCnt[0], 0);

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            load = ($urandom_range(0, 19) == 0);
            data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
            dpIn = 4'($urandom);
            blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 99) == 0) lzSuppress = ~lzSuppress;
            rst = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        repeat (FRAME) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
